// File: rtl/sdram_read_sequencer_if.sv
// Bundles the read sequencer's request/address/data handshake and SDRAM command bus.
// master: the sequencer; slave: the surrounding address counter, arbiter and SDRAM model.
interface sdram_read_sequencer_if;
  logic        READ_REQ;
  logic        INHIBIT;
  logic [1:0]  BA_IN;
  logic [12:0] ROW_IN;
  logic [8:0]  COL_IN;
  logic [15:0] DQ_IN;
  logic        NEXT;
  logic        BUSY;
  logic        CS_N;
  logic        RAS_N;
  logic        CAS_N;
  logic        WE_N;
  logic [1:0]  SD_BA;
  logic [12:0] SD_ADDR;
  logic [15:0] DATA_OUT;
  logic        DATA_VALID;

  modport master (
    input  READ_REQ, INHIBIT, BA_IN, ROW_IN, COL_IN, DQ_IN,
    output NEXT, BUSY, CS_N, RAS_N, CAS_N, WE_N, SD_BA, SD_ADDR, DATA_OUT, DATA_VALID
  );

  modport slave (
    output READ_REQ, INHIBIT, BA_IN, ROW_IN, COL_IN, DQ_IN,
    input  NEXT, BUSY, CS_N, RAS_N, CAS_N, WE_N, SD_BA, SD_ADDR, DATA_OUT, DATA_VALID
  );
endinterface

// File: rtl/sdram_read_sequencer.sv
// Single-word SDRAM read sequencer: ACTIVE, READ, capture, PRECHARGE, then NEXT to the counter.
// Define SDRAM_READ_AUTO_PRECHARGE_EN to issue READ with auto-precharge instead of PRECHARGE.
module sdram_read_sequencer #(
  parameter int unsigned T_RCD   = 2,
  parameter int unsigned CAS_LAT = 2,
  parameter int unsigned T_RAS   = 5,
  parameter int unsigned T_RP    = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  sdram_read_sequencer_if.master       bus
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StActivate  = 3'd1;
  localparam logic [2:0] StWaitRcd   = 3'd2;
  localparam logic [2:0] StReadCmd   = 3'd3;
  localparam logic [2:0] StWaitCas   = 3'd4;
  localparam logic [2:0] StCapture   = 3'd5;
  localparam logic [2:0] StPrecharge = 3'd6;
  localparam logic [2:0] StWaitRp    = 3'd7;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CmdNop    = 4'b0111;
  localparam logic [3:0] CmdActive = 4'b0011;
  localparam logic [3:0] CmdRead   = 4'b0101;
  localparam logic [3:0] CmdPre    = 4'b0010;

`ifdef SDRAM_READ_AUTO_PRECHARGE_EN
  localparam logic [3:0] ReadHi   = 4'b0010;
  localparam logic [3:0] CmdClose = CmdNop;
`else
  localparam logic [3:0] ReadHi   = 4'b0000;
  localparam logic [3:0] CmdClose = CmdPre;
`endif

  // Wait-state lengths; a zero length skips the wait state entirely.
  localparam logic [3:0] RcdWait = 4'(T_RCD - 1);
  localparam logic [3:0] CasWait = 4'(CAS_LAT - 1);
  localparam logic [3:0] RpWait  = 4'(T_RP);
  localparam logic [5:0] RasCyc  = 6'(T_RAS);

  logic [2:0]  state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [5:0]  cyc_q, cyc_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        dv_q, dv_d;
  logic        next_q, next_d;
  logic        busy_q, busy_d;
  logic [1:0]  bank_q, bank_d;
  logic [8:0]  col_q, col_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cyc_d   = cyc_q;
    cmd_d   = CmdNop;
    ba_d    = ba_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    next_d  = 1'b0;
    busy_d  = busy_q;
    bank_d  = bank_q;
    col_d   = col_q;

    // cyc_q numbers the current cycle of the sequence, with ACTIVE as cycle 1.
    if (state_q != StIdle) begin
      cyc_d = cyc_q + 6'd1;
    end

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (bus.READ_REQ && !bus.INHIBIT) begin
          state_d = StActivate;
          cmd_d   = CmdActive;
          ba_d    = bus.BA_IN;
          addr_d  = bus.ROW_IN;
          bank_d  = bus.BA_IN;
          col_d   = bus.COL_IN;
          busy_d  = 1'b1;
          cyc_d   = 6'd1;
        end
      end

      StActivate: begin
        if (RcdWait == 4'd0) begin
          state_d = StReadCmd;
          cmd_d   = CmdRead;
          ba_d    = bank_q;
          addr_d  = {ReadHi, col_q};
        end else begin
          state_d = StWaitRcd;
          wait_d  = RcdWait;
        end
      end

      StWaitRcd: begin
        if (wait_q <= 4'd1) begin
          state_d = StReadCmd;
          cmd_d   = CmdRead;
          ba_d    = bank_q;
          addr_d  = {ReadHi, col_q};
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      StReadCmd: begin
        if (CasWait == 4'd0) begin
          state_d = StCapture;
        end else begin
          state_d = StWaitCas;
          wait_d  = CasWait;
        end
      end

      StWaitCas: begin
        if (wait_q <= 4'd1) begin
          state_d = StCapture;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      // DQ is sampled at the end of this cycle; the bank closes once tRAS has elapsed.
      StCapture: begin
        dout_d  = bus.DQ_IN;
        dv_d    = 1'b1;
        state_d = StPrecharge;
        if (cyc_q >= RasCyc) begin
          cmd_d  = CmdClose;
          next_d = 1'b1;
          ba_d   = bank_q;
          addr_d = '0;
        end
      end

      // Holds NOPs until tRAS is met; next_q marks the cycle the bank is closed.
      StPrecharge: begin
        if (next_q) begin
          if (RpWait == 4'd0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d = StWaitRp;
            wait_d  = RpWait;
          end
        end else if (cyc_q >= RasCyc) begin
          cmd_d  = CmdClose;
          next_d = 1'b1;
          ba_d   = bank_q;
          addr_d = '0;
        end
      end

      StWaitRp: begin
        if (wait_q <= 4'd1) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      wait_q  <= '0;
      cyc_q   <= '0;
      cmd_q   <= CmdNop;
      ba_q    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      next_q  <= 1'b0;
      busy_q  <= 1'b0;
      bank_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      next_q  <= next_d;
      busy_q  <= busy_d;
      bank_q  <= bank_d;
      col_q   <= col_d;
    end
  end

  assign bus.CS_N       = cmd_q[3];
  assign bus.RAS_N      = cmd_q[2];
  assign bus.CAS_N      = cmd_q[1];
  assign bus.WE_N       = cmd_q[0];
  assign bus.SD_BA      = ba_q;
  assign bus.SD_ADDR    = addr_q;
  assign bus.DATA_OUT   = dout_q;
  assign bus.DATA_VALID = dv_q;
  assign bus.NEXT       = next_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_sdram_read_sequencer.sv
// Directed bench for sdram_read_sequencer with a row-incrementing address counter model.
// Define SDRAM_READ_AUTO_PRECHARGE_EN to exercise the auto-precharge build (T_RAS=8).
module tb_sdram_read_sequencer;

  localparam int unsigned TRcd   = 2;
  localparam int unsigned CasLat = 2;
  localparam int unsigned TRp    = 2;
`ifdef SDRAM_READ_AUTO_PRECHARGE_EN
  localparam int unsigned TRas = 8;
  localparam bit          Ap   = 1'b1;
`else
  localparam int unsigned TRas = 5;
  localparam bit          Ap   = 1'b0;
`endif
  localparam int Rc  = 1 + TRcd;                           // READ cycle
  localparam int Cc  = Rc + CasLat;                        // DQ sampled at end of this cycle
  localparam int Pc  = (Cc + 1 > 1 + TRas) ? Cc + 1 : 1 + TRas;
  localparam int Per = Pc + TRp + 1;                       // ACTIVE-to-ACTIVE with REQ held

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdPre = 4'b0010;

  typedef struct {
    logic        req;
    logic [15:0] dq;
    logic [3:0]  cmd;
    logic        busy;
    logic        next;
    logic        dv;
    logic [12:0] amask;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dout;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  sdram_read_sequencer_if bus ();

  sdram_read_sequencer #(
    .T_RCD  (TRcd),
    .CAS_LAT(CasLat),
    .T_RAS  (TRas),
    .T_RP   (TRp)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  // Address counter model: advances ROW on each NEXT, unaffected by the sequencer's reset.
  logic        ld;
  logic [1:0]  ld_ba;
  logic [12:0] ld_row;
  logic [8:0]  ld_col;
  logic [1:0]  ctr_ba;
  logic [12:0] ctr_row;
  logic [8:0]  ctr_col;

  always @(posedge CLK) begin
    if (ld) begin
      ctr_ba  <= ld_ba;
      ctr_row <= ld_row;
      ctr_col <= ld_col;
    end else if (bus.NEXT) begin
      ctr_row <= ctr_row + 13'd1;
    end
  end

  assign bus.BA_IN  = ctr_ba;
  assign bus.ROW_IN = ctr_row;
  assign bus.COL_IN = ctr_col;

  wire [3:0] cmd = {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (!bus.BUSY) break;
      step();
    end
    chk(name, {31'd0, bus.BUSY}, 32'd0);
  endtask

  vec_t        tv[$];
  vec_t        v;
  int          n_next;
  int          n_act;
  int          got;
  logic [12:0] row0;

  initial begin
    bus.READ_REQ = 1'b0;
    bus.INHIBIT  = 1'b0;
    bus.DQ_IN    = 16'h0000;
    ld     = 1'b1;
    ld_ba  = 2'd2;
    ld_row = 13'h1ABC;
    ld_col = 9'h155;

    // Reset release with no request: idle, NOP bus, reset values.
    repeat (3) step();
    RESET = 1'b1;
    ld    = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("rst_cmd@%0d", k), {28'd0, cmd}, {28'd0, CmdNop});
      chk($sformatf("rst_busy@%0d", k), {31'd0, bus.BUSY}, 32'd0);
      chk($sformatf("rst_next@%0d", k), {31'd0, bus.NEXT}, 32'd0);
      chk($sformatf("rst_dv@%0d", k), {31'd0, bus.DATA_VALID}, 32'd0);
      chk($sformatf("rst_dout@%0d", k), {16'd0, bus.DATA_OUT}, 32'd0);
      chk($sformatf("rst_ba@%0d", k), {30'd0, bus.SD_BA}, 32'd0);
      chk($sformatf("rst_addr@%0d", k), {19'd0, bus.SD_ADDR}, 32'd0);
    end

    // Single read: BA=2 ROW=1ABC COL=155, DQ=BEEF only in the capture cycle.
    for (int k = 0; k <= Per + 1; k++) begin
      v.req   = (k == 0);
      v.dq    = (k == Cc) ? 16'hBEEF : 16'h1000 + 16'(k);
      v.cmd   = (k == 1) ? CmdAct : (k == Rc) ? CmdRd : (k == Pc && !Ap) ? CmdPre : CmdNop;
      v.busy  = (k >= 1) && (k <= Pc + TRp);
      v.next  = (k == Pc);
      v.dv    = (k == Cc + 1);
      v.amask = 13'h0000;
      v.ba    = 2'd2;
      v.addr  = 13'h0000;
      v.dout  = (k >= Cc + 1) ? 16'hBEEF : 16'h0000;
      if (k == 1) begin
        v.amask = 13'h1FFF;
        v.addr  = 13'h1ABC;
      end else if (k == Rc) begin
        v.amask = 13'h1FFF;
        v.addr  = Ap ? 13'h0555 : 13'h0155;
      end else if (k == Pc && !Ap) begin
        v.amask = 13'h0400;
      end
      tv.push_back(v);
    end

    foreach (tv[k]) begin
      step();
      bus.READ_REQ = tv[k].req;
      bus.DQ_IN    = tv[k].dq;
      chk($sformatf("rd_cmd@%0d", k), {28'd0, cmd}, {28'd0, tv[k].cmd});
      chk($sformatf("rd_busy@%0d", k), {31'd0, bus.BUSY}, {31'd0, tv[k].busy});
      chk($sformatf("rd_next@%0d", k), {31'd0, bus.NEXT}, {31'd0, tv[k].next});
      chk($sformatf("rd_dv@%0d", k), {31'd0, bus.DATA_VALID}, {31'd0, tv[k].dv});
      chk($sformatf("rd_dout@%0d", k), {16'd0, bus.DATA_OUT}, {16'd0, tv[k].dout});
      if (tv[k].amask != 13'h0000) begin
        chk($sformatf("rd_ba@%0d", k), {30'd0, bus.SD_BA}, {30'd0, tv[k].ba});
        chk($sformatf("rd_addr@%0d", k), {19'd0, bus.SD_ADDR & tv[k].amask},
            {19'd0, tv[k].addr & tv[k].amask});
      end
    end
    chk("rd_ctr_row", {19'd0, ctr_row}, 32'h1ABD);

    // READ_REQ held for three reads with the counter attached.
    ld     = 1'b1;
    ld_ba  = 2'd0;
    ld_row = 13'd0;
    ld_col = 9'd0;
    step();
    ld     = 1'b0;
    n_next = 0;
    n_act  = 0;
    for (int k = 0; k <= 3 * Per + 1; k++) begin
      step();
      bus.READ_REQ = (k <= 2 * Per);
      if (bus.NEXT) n_next++;
      if (cmd == CmdAct) n_act++;
      if (k == 1 || k == 1 + Per || k == 1 + 2 * Per) begin
        chk($sformatf("hold_act@%0d", k), {28'd0, cmd}, {28'd0, CmdAct});
        chk($sformatf("hold_row@%0d", k), {19'd0, bus.SD_ADDR}, 32'((k - 1) / Per));
      end
    end
    chk("hold_nexts", n_next, 3);
    chk("hold_acts", n_act, 3);
    chk("hold_ctr_row", {19'd0, ctr_row}, 32'd3);
    chk("hold_idle", {31'd0, bus.BUSY}, 32'd0);

    // INHIBIT with READ_REQ: nothing issued; ACTIVE one cycle after INHIBIT drops.
    for (int k = 0; k <= 6; k++) begin
      step();
      bus.READ_REQ = (k <= 5);
      bus.INHIBIT  = (k < 5);
      if (k >= 1 && k <= 5) begin
        chk($sformatf("inh_cmd@%0d", k), {28'd0, cmd}, {28'd0, CmdNop});
        chk($sformatf("inh_busy@%0d", k), {31'd0, bus.BUSY}, 32'd0);
      end
    end
    chk("inh_act", {28'd0, cmd}, {28'd0, CmdAct});
    // INHIBIT rising mid-sequence must not stop the read.
    step();
    bus.INHIBIT = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      step();
      if (bus.NEXT) got = 1;
    end
    chk("inh_mid_next", got, 1);
    bus.INHIBIT = 1'b0;
    wait_idle("inh_idle");

    // RESET low in cycle 4 of a read: NOP at once, no NEXT/DATA_VALID, address kept.
    row0 = ctr_row;
    step();
    bus.READ_REQ = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.READ_REQ = 1'b0;
    end
    chk("abort_busy_before", {31'd0, bus.BUSY}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("abort_cmd", {28'd0, cmd}, {28'd0, CmdNop});
    chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("abort_next", {31'd0, bus.NEXT}, 32'd0);
    chk("abort_dv", {31'd0, bus.DATA_VALID}, 32'd0);
    n_next = 0;
    got    = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (k == 2) RESET = 1'b1;
      if (bus.NEXT) n_next++;
      if (bus.DATA_VALID) got++;
    end
    chk("abort_no_next", n_next, 0);
    chk("abort_no_dv", got, 0);
    chk("abort_ctr_row", {19'd0, ctr_row}, {19'd0, row0});
    chk("abort_idle", {31'd0, bus.BUSY}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_read_sequencer.md
Name: sdram_read_sequencer

Overview:
- Downstream consumer of the SDRAM read-address counter (BA[1:0]/ROW[12:0]/COL[8:0], advanced on NEXT rising edge).
- Per read request it latches the current address and runs one single-word SDRAM read: ACTIVE, READ, capture, PRECHARGE.
- It presents the 16-bit word, then pulses NEXT so the counter advances to the following address.
- It owns the SDRAM command bus only while BUSY is high; the write/refresh path holds off via INHIBIT.

Parameters:
- T_RCD, 2: clocks from ACTIVE to READ (min 1).
- CAS_LAT, 2: clocks from READ to data valid on DQ_IN (2 or 3).
- T_RAS, 5: min clocks from ACTIVE to PRECHARGE.
- T_RP, 2: clocks after PRECHARGE before returning to IDLE.

Ports:
- CLK, input, 1: system clock, all logic on rising edge.
- RESET, input, 1: asynchronous, active-low reset.
- READ_REQ, input, 1: level request for one word read; sampled only in IDLE.
- INHIBIT, input, 1: bus held by write/refresh; blocks new reads; sampled only in IDLE.
- BA_IN, input, 2: bank from address counter.
- ROW_IN, input, 13: row from address counter.
- COL_IN, input, 9: column from address counter.
- DQ_IN, input, 16: SDRAM read data.
- NEXT, output, 1: one-CLK pulse advancing the address counter.
- BUSY, output, 1: sequence in progress / command bus owned.
- CS_N, output, 1: SDRAM command bit.
- RAS_N, output, 1: SDRAM command bit.
- CAS_N, output, 1: SDRAM command bit.
- WE_N, output, 1: SDRAM command bit.
- SD_BA, output, 2: SDRAM bank address.
- SD_ADDR, output, 13: SDRAM address bus.
- DATA_OUT, output, 16: last captured word.
- DATA_VALID, output, 1: one-CLK strobe, DATA_OUT updated.

Behaviour:
- All outputs registered.
- Reset values:
  - NOP: CS_N=0, RAS_N=1, CAS_N=1, WE_N=1.
  - SD_BA=0, SD_ADDR=0, DATA_OUT=0.
  - NEXT=0, DATA_VALID=0, BUSY=0.
  - State IDLE; internal counters 0.
- Commands as CS_N/RAS_N/CAS_N/WE_N:
  - ACTIVE 0011: SD_BA=BA, SD_ADDR=ROW.
  - READ 0101: SD_ADDR={4'b0,COL}; A10=0 unless the optional feature is enabled.
  - PRECHARGE 0010: SD_BA=BA, A10=0 (single bank).
  - NOP in every other cycle.
- States: IDLE, ACTIVATE, WAIT_RCD, READ_CMD, WAIT_CAS, CAPTURE, PRECHARGE, WAIT_RP.
- Start: in IDLE with READ_REQ=1 and INHIBIT=0 at edge of cycle 0:
  - BA_IN/ROW_IN/COL_IN latched at that edge.
  - ACTIVE is driven in cycle 1; BUSY=1 from cycle 1.
- INHIBIT=1 in IDLE blocks start regardless of READ_REQ (INHIBIT wins a simultaneous assertion).
- INHIBIT rising mid-sequence is ignored; the sequence completes.
- Timing, with A = cycle 1:
  - READ in cycle R = 1+T_RCD.
  - DQ_IN sampled at the end of cycle C = R+CAS_LAT.
  - DATA_OUT updated and DATA_VALID=1 in cycle C+1.
  - PRECHARGE and NEXT=1 in cycle P = max(C+1, 1+T_RAS); extra cycles before P are NOPs.
  - WAIT_RP covers T_RP NOP cycles; IDLE with BUSY=0 in cycle P+T_RP+1.
- Defaults: ACTIVE 1, READ 3, DATA_VALID 6, PRECHARGE/NEXT 6, BUSY low in cycle 9.
- READ_REQ held high: next ACTIVE at cycle P+T_RP+2 (cycle 10 with defaults), using the post-NEXT address.
- NEXT is exactly one CLK wide, once per completed read. Address wrap is owned by the counter; the sequencer ignores it.
- DATA_OUT holds its value between reads.
- Wait counters are wide enough for parameter max 15.
- RESET low mid-sequence:
  - Immediately NOP; BUSY=0, NEXT=0, DATA_VALID=0.
  - No NEXT pulse is issued for the aborted read; the address is not advanced.

Optional Feature:
- Macro: SDRAM_READ_AUTO_PRECHARGE_EN.
- Defined:
  - READ issued with SD_ADDR[10]=1 (auto-precharge).
  - PRECHARGE state removed; cycle P drives NOP.
  - NEXT is still pulsed in cycle P; all other timing is identical.
- Undefined: explicit PRECHARGE as above.

Test Plan:
- Reset release, READ_REQ=0: all outputs at reset values, NOP on bus, BUSY=0 for 20 cycles.
- Defaults; BA=2, ROW=0x1ABC, COL=0x155; READ_REQ pulse in cycle 0; DQ_IN=0xBEEF in cycle 5:
  - ACTIVE cycle 1 with SD_ADDR=0x1ABC, SD_BA=2.
  - READ cycle 3 with SD_ADDR=0x0155.
  - DATA_OUT=0xBEEF with DATA_VALID=1 in cycle 6; PRECHARGE and NEXT in cycle 6.
  - BUSY=0 in cycle 9.
- READ_REQ held high for 3 reads with address counter attached: exactly 3 NEXT pulses; ACTIVEs at cycles 1, 10, 19; ROW increments 0, 1, 2.
- INHIBIT=1 and READ_REQ=1 together for 5 cycles: no command issued. INHIBIT drops: ACTIVE on the next cycle.
- RESET low in cycle 4 of a read: NOP immediately; no NEXT and no DATA_VALID; counter address unchanged.
- SDRAM_READ_AUTO_PRECHARGE_EN defined, T_RAS=8: READ has SD_ADDR[10]=1; no PRECHARGE command; NEXT in cycle 9; BUSY=0 in cycle 12.
